// File: rtl/layer_sequencer.sv
// Purpose : steps input/neuron indices for one fully-connected layer and drives MAC and writeback.
// Latency : per neuron 1 (clear) + in_max+1 (accumulate) + MAC_LAT (drain) + 1 (write) cycles, plus 1 done cycle per layer.
// Backpr. : WRITE holds wb_valid and neuron_addr until wb_ready is seen at a rising edge.
//
// Ports:
//   CLOCK, resetn            clock and asynchronous active-low reset
//   start, abort             begin a layer (IDLE only) / return to IDLE from any state
//   in_max, n_max            last input / neuron index, latched when start is accepted
//   in_addr, neuron_addr     current input column and neuron row
//   mac_clear, mac_en        accumulator clear and accumulate strobes
//   wb_valid, wb_ready       neuron result writeback handshake
//   busy, done               activity flag and one-cycle end-of-layer pulse
module layer_sequencer #(
    parameter int IDX_W   = 5,
    parameter int MAC_LAT = 2
) (
    input  logic             CLOCK,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] in_max,
    input  logic [IDX_W-1:0] n_max,
    output logic [IDX_W-1:0] in_addr,
    output logic [IDX_W-1:0] neuron_addr,
    output logic             mac_clear,
    output logic             mac_en,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             busy,
    output logic             done
);

    // Drain counter is 4 bits wide, enough for MAC_LAT up to 15.
    localparam logic [3:0] LAT = 4'(MAC_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] in_addr_q, in_addr_d;
    logic [IDX_W-1:0] neuron_q, neuron_d;
    logic [IDX_W-1:0] in_max_q, in_max_d;
    logic [IDX_W-1:0] n_max_q, n_max_d;
    logic [3:0]       drain_q, drain_d;

    logic mac_clear_q, mac_en_q, wb_valid_q, busy_q, done_q;

    // Next-state logic. Abort overrides everything, including start and the
    // writeback handshake on the same edge.
    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        neuron_d  = neuron_q;
        in_max_d  = in_max_q;
        n_max_d   = n_max_q;
        drain_d   = drain_q;

        if (abort) begin
            state_d   = S_IDLE;
            in_addr_d = '0;
            neuron_d  = '0;
            drain_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        in_max_d  = in_max;
                        n_max_d   = n_max;
                        neuron_d  = '0;
                        in_addr_d = '0;
                        state_d   = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    in_addr_d = '0;
                    state_d   = S_ACCUM;
                end
                S_ACCUM: begin
                    // Equality compare against the latched max, so an all-ones
                    // max finishes without the index ever wrapping.
                    if (in_addr_q == in_max_q) begin
                        if (LAT == 4'd0) begin
                            state_d = S_WRITE;
                        end else begin
                            drain_d = LAT;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        in_addr_d = in_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q <= 4'd1) begin
                        drain_d = '0;
                        state_d = S_WRITE;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (wb_ready) begin
                        if (neuron_q == n_max_q) begin
                            state_d = S_DONE;
                        end else begin
                            neuron_d  = neuron_q + 1'b1;
                            in_addr_d = '0;
                            state_d   = S_CLEAR;
                        end
                    end
                end
                S_DONE: begin
                    in_addr_d = '0;
                    neuron_d  = '0;
                    state_d   = S_IDLE;
                end
                default: begin
                    in_addr_d = '0;
                    neuron_d  = '0;
                    drain_d   = '0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change exactly when the state does and have no input paths.
    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            in_addr_q   <= '0;
            neuron_q    <= '0;
            in_max_q    <= '0;
            n_max_q     <= '0;
            drain_q     <= '0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            neuron_q    <= neuron_d;
            in_max_q    <= in_max_d;
            n_max_q     <= n_max_d;
            drain_q     <= drain_d;
            mac_clear_q <= (state_d == S_CLEAR);
            mac_en_q    <= (state_d == S_ACCUM);
            wb_valid_q  <= (state_d == S_WRITE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign in_addr     = in_addr_q;
    assign neuron_addr = neuron_q;
    assign mac_clear   = mac_clear_q;
    assign mac_en      = mac_en_q;
    assign wb_valid    = wb_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

    logic       CLOCK = 1'b0;
    logic       resetn;
    logic       start, start0, abort, wb_ready;
    logic [4:0] in_max, n_max;

    logic [4:0] in_addr, neuron_addr, in_addr0, neuron_addr0;
    logic       mac_clear, mac_en, wb_valid, busy, done;
    logic       mac_clear0, mac_en0, wb_valid0, busy0, done0;
    logic [4:0] ctl, ctl0;

    int checks = 0;
    int errors = 0;

    layer_sequencer #(.IDX_W(5), .MAC_LAT(2)) dut (
        .CLOCK(CLOCK), .resetn(resetn), .start(start), .abort(abort),
        .in_max(in_max), .n_max(n_max), .in_addr(in_addr), .neuron_addr(neuron_addr),
        .mac_clear(mac_clear), .mac_en(mac_en), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .busy(busy), .done(done)
    );

    layer_sequencer #(.IDX_W(5), .MAC_LAT(0)) dut0 (
        .CLOCK(CLOCK), .resetn(resetn), .start(start0), .abort(abort),
        .in_max(in_max), .n_max(n_max), .in_addr(in_addr0), .neuron_addr(neuron_addr0),
        .mac_clear(mac_clear0), .mac_en(mac_en0), .wb_valid(wb_valid0), .wb_ready(wb_ready),
        .busy(busy0), .done(done0)
    );

    // {busy, done, mac_clear, mac_en, wb_valid}
    assign ctl  = {busy, done, mac_clear, mac_en, wb_valid};
    assign ctl0 = {busy0, done0, mac_clear0, mac_en0, wb_valid0};

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Expected control vector for the reference layer (MAC_LAT=2, in_max=3,
    // n_max=1) in cycle c after the start edge, with the first WRITE stalled s cycles.
    function automatic logic [4:0] exp_ctl(input int c, input int s);
        logic b, d, cl, e, w;
        b  = (c >= 1 && c <= 17 + s);
        d  = (c == 17 + s);
        cl = (c == 1 || c == 9 + s);
        e  = (c >= 2 && c <= 5) || (c >= 10 + s && c <= 13 + s);
        w  = (c >= 8 && c <= 8 + s) || (c == 16 + s);
        return {b, d, cl, e, w};
    endfunction

    // Reference layer run. s = first-WRITE stall length; poke = pulse start
    // in two busy cycles and in the DONE cycle, all of which must be ignored.
    task automatic run_ref(input string nm, input int s, input bit poke);
        logic [4:0] ex;
        in_max   = 5'd3;
        n_max    = 5'd1;
        wb_ready = 1'b1;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        // Must not affect the layer already running.
        in_max = 5'd9;
        n_max  = 5'd4;
        for (int c = 1; c <= 20 + s; c++) begin
            wb_ready = !(s > 0 && c >= 8 && c < 8 + s);
            start    = poke && (c == 4 || c == 12 + s || c == 17 + s);
            ex = exp_ctl(c, s);
            check($sformatf("%s c%0d ctl", nm, c), 32'(ctl), 32'(ex));
            if (ex[1])
                check($sformatf("%s c%0d in_addr", nm, c), 32'(in_addr),
                      (c <= 5) ? 32'(c - 2) : 32'(c - 10 - s));
            if (ex[0])
                check($sformatf("%s c%0d neuron", nm, c), 32'(neuron_addr),
                      (c <= 8 + s) ? 32'd0 : 32'd1);
            tick();
        end
        start    = 1'b0;
        wb_ready = 1'b1;
    endtask

    initial begin
        logic [4:0] t2_ctl [1:5];
        int ens, bad_in, wbs, bad_wb, dones, done_c, exp_in, max_in;

        resetn   = 1'b0;
        start    = 1'b0;
        start0   = 1'b0;
        abort    = 1'b0;
        wb_ready = 1'b1;
        in_max   = 5'd0;
        n_max    = 5'd0;
        #12;
        check("rst ctl", 32'(ctl), 32'd0);
        check("rst in_addr", 32'(in_addr), 32'd0);
        check("rst neuron", 32'(neuron_addr), 32'd0);
        check("rst ctl0", 32'(ctl0), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("idle ctl", 32'(ctl), 32'd0);

        // 1: reference timing.
        run_ref("t1", 0, 1'b0);

        // 2: minimal layer on the zero-latency instance.
        t2_ctl[1] = 5'b10100;
        t2_ctl[2] = 5'b10010;
        t2_ctl[3] = 5'b10001;
        t2_ctl[4] = 5'b11000;
        t2_ctl[5] = 5'b00000;
        in_max = 5'd0;
        n_max  = 5'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t2 c%0d ctl", c), 32'(ctl0), 32'(t2_ctl[c]));
            if (c == 2) check("t2 in_addr", 32'(in_addr0), 32'd0);
            if (c == 3) check("t2 neuron", 32'(neuron_addr0), 32'd0);
            tick();
        end

        // 3: writeback stalled for 5 cycles.
        run_ref("t3", 5, 1'b0);

        // 4: abort during ACCUM, then a fresh layer.
        in_max = 5'd3;
        n_max  = 5'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            abort = (c == 4);
            check($sformatf("t4 c%0d ctl", c), 32'(ctl), (c <= 4) ? 32'(exp_ctl(c, 0)) : 32'd0);
            if (c == 5) begin
                check("t4 in_addr", 32'(in_addr), 32'd0);
                check("t4 neuron", 32'(neuron_addr), 32'd0);
            end
            tick();
        end
        abort = 1'b0;
        run_ref("t4r", 0, 1'b0);

        // 5: reset between edges mid-ACCUM, then ignored start pulses.
        in_max = 5'd3;
        n_max  = 5'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5 pre ctl", 32'(ctl), 32'(exp_ctl(3, 0)));
        #2;
        resetn = 1'b0;
        #1;
        check("t5 rst ctl", 32'(ctl), 32'd0);
        check("t5 rst in_addr", 32'(in_addr), 32'd0);
        check("t5 rst neuron", 32'(neuron_addr), 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        check("t5 idle ctl", 32'(ctl), 32'd0);
        run_ref("t5", 0, 1'b1);

        // 6: full-size layer, no index wrap.
        in_max = 5'd31;
        n_max  = 5'd31;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ens = 0; bad_in = 0; wbs = 0; bad_wb = 0;
        dones = 0; done_c = 0; exp_in = 0; max_in = 0;
        for (int c = 1; c <= 1200; c++) begin
            if (mac_en) begin
                if (int'(in_addr) != exp_in) bad_in++;
                if (int'(in_addr) > max_in) max_in = int'(in_addr);
                exp_in = (exp_in == 31) ? 0 : exp_in + 1;
                ens++;
            end
            if (wb_valid) begin
                if (int'(neuron_addr) != wbs) bad_wb++;
                wbs++;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
            tick();
        end
        check("t6 max in_addr", 32'(max_in), 32'd31);
        check("t6 in_addr seq", 32'(bad_in), 32'd0);
        check("t6 mac_en cycles", 32'(ens), 32'd1024);
        check("t6 writebacks", 32'(wbs), 32'd32);
        check("t6 wb addr seq", 32'(bad_wb), 32'd0);
        check("t6 done count", 32'(dones), 32'd1);
        check("t6 done cycle", 32'(done_c), 32'd1153);
        check("t6 end busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
